// File: rtl/calculator_pkg.sv
// Shared calculator widths, the operand loader state encoding and the half-word placement helper.
package calculator_pkg;

    localparam int ADDR_W        = 9;
    localparam int DATA_W        = 32;
    localparam int MEM_WORD_SIZE = 64;

    typedef enum logic [2:0] {LD_IDLE, LD_LO, LD_HI, LD_WR, LD_DONE} loader_state_t;

    // Returns word with one half replaced by beat; upper selects [MEM_WORD_SIZE-1:DATA_W].
    function automatic logic [MEM_WORD_SIZE-1:0] place_beat(
        input logic [MEM_WORD_SIZE-1:0] word,
        input logic [DATA_W-1:0]        beat,
        input logic                     upper
    );
        logic [MEM_WORD_SIZE-1:0] res;
        if (upper) begin
            res = {beat, word[DATA_W-1:0]};
        end else begin
            res = {word[MEM_WORD_SIZE-1:DATA_W], beat};
        end
        return res;
    endfunction

endpackage

// File: rtl/word_packer.sv
// Two-beat pair register; places each beat in its half according to LO_FIRST.
// word presents the pair including a beat being loaded this cycle, so a completed word is visible immediately.
module word_packer
    import calculator_pkg::*;
#(
    parameter logic LO_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_first,
    input  logic                     load_second,
    input  logic [DATA_W-1:0]        beat,
    output logic [MEM_WORD_SIZE-1:0] word
);

    logic [MEM_WORD_SIZE-1:0] pair_r;
    logic [MEM_WORD_SIZE-1:0] pair_next_s;

    // Merge the incoming beat into the half it belongs to
    always_comb begin
        pair_next_s = pair_r;
        if (load_first) begin
            pair_next_s = place_beat(pair_r, beat, ~LO_FIRST);
        end else if (load_second) begin
            pair_next_s = place_beat(pair_r, beat, LO_FIRST);
        end else begin
            pair_next_s = pair_r;
        end
    end

    // Pair storage; reset discards any incomplete pair
    always_ff @(posedge clk) begin
        if (rst) begin
            pair_r <= {MEM_WORD_SIZE{1'b0}};
        end else begin
            pair_r <= pair_next_s;
        end
    end

    assign word = pair_next_s;

endmodule

// File: rtl/operand_loader.sv
// Streams 32-bit operand pairs into consecutive 64-bit SRAM words from base to end, then pulses done.
// Optional LOADER_CHECKSUM_EN adds checksum_o, the modulo-2^DATA_W sum of all beats of the run.
module operand_loader
    import calculator_pkg::*;
#(
    parameter logic LO_FIRST = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [ADDR_W-1:0]        base_addr_i,
    input  logic [ADDR_W-1:0]        end_addr_i,
    input  logic                     in_valid_i,
    input  logic [DATA_W-1:0]        in_data_i,
    output logic                     in_ready_o,
    output logic                     write_o,
    output logic [ADDR_W-1:0]        w_addr_o,
    output logic [MEM_WORD_SIZE-1:0] w_data_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]        checksum_o
`endif
);

    loader_state_t            state_r;
    logic [ADDR_W-1:0]        addr_r;
    logic [ADDR_W-1:0]        end_r;
    logic                     beat_fire_s;
    logic                     load_first_s;
    logic                     load_second_s;
    logic                     range_ok_s;
    logic [MEM_WORD_SIZE-1:0] word_s;

    assign beat_fire_s   = in_valid_i & in_ready_o;
    assign load_first_s  = beat_fire_s & (state_r == LD_LO);
    assign load_second_s = beat_fire_s & (state_r == LD_HI);
    assign range_ok_s    = (end_addr_i >= base_addr_i);

    word_packer #(
        .LO_FIRST   (LO_FIRST)
    ) u_packer (
        .clk        (clk_i),
        .rst        (rst_i),
        .load_first (load_first_s),
        .load_second(load_second_s),
        .beat       (in_data_i),
        .word       (word_s)
    );

    // Load FSM; the write strobe is launched on the second beat so it is high during LD_WR
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= LD_IDLE;
            addr_r     <= {ADDR_W{1'b0}};
            end_r      <= {ADDR_W{1'b0}};
            in_ready_o <= 1'b0;
            write_o    <= 1'b0;
            w_addr_o   <= {ADDR_W{1'b0}};
            w_data_o   <= {MEM_WORD_SIZE{1'b0}};
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            write_o <= 1'b0;
            done_o  <= 1'b0;
            case (state_r)
                LD_IDLE: begin
                    if (start_i && range_ok_s) begin
                        err_o      <= 1'b0;
                        addr_r     <= base_addr_i;
                        end_r      <= end_addr_i;
                        busy_o     <= 1'b1;
                        in_ready_o <= 1'b1;
                        state_r    <= LD_LO;
                    end else if (start_i) begin
                        err_o <= 1'b1;
                    end
                end
                LD_LO: begin
                    if (beat_fire_s) begin
                        state_r <= LD_HI;
                    end
                end
                LD_HI: begin
                    if (beat_fire_s) begin
                        in_ready_o <= 1'b0;
                        write_o    <= 1'b1;
                        w_addr_o   <= addr_r;
                        w_data_o   <= word_s;
                        state_r    <= LD_WR;
                    end
                end
                LD_WR: begin
                    // Equality compare keeps the top address legal without overflow
                    if (addr_r == end_r) begin
                        done_o  <= 1'b1;
                        state_r <= LD_DONE;
                    end else begin
                        addr_r     <= addr_r + ADDR_W'(1);
                        in_ready_o <= 1'b1;
                        state_r    <= LD_LO;
                    end
                end
                LD_DONE: begin
                    busy_o  <= 1'b0;
                    state_r <= LD_IDLE;
                end
                default: begin
                    in_ready_o <= 1'b0;
                    busy_o     <= 1'b0;
                    state_r    <= LD_IDLE;
                end
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running sum of accepted beats, restarted by each accepted start
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            checksum_o <= {DATA_W{1'b0}};
        end else if ((state_r == LD_IDLE) && start_i && range_ok_s) begin
            checksum_o <= {DATA_W{1'b0}};
        end else if (beat_fire_s) begin
            checksum_o <= checksum_o + in_data_i;
        end else begin
            checksum_o <= checksum_o;
        end
    end
`endif

endmodule
